// File: rtl/clk_period_meter_if.sv
// rtl/clk_period_meter_if.sv - control and result signals of the clock period meter
interface clk_period_meter_if #(
    parameter int CNT_W = 25
);
    logic             enable;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             timeout;

    modport master (
        output enable,
        output sig_in,
        input  period,
        input  high_time,
        input  valid,
        input  timeout
    );

    modport slave (
        input  enable,
        input  sig_in,
        output period,
        output high_time,
        output valid,
        output timeout
    );
endinterface

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - measures period and high time of a slow asynchronous square wave
module clk_period_meter #(
    parameter int CNT_W       = 25,
    parameter int TIMEOUT_CYC = 20_000_000
) (
    input logic            clk,
    input logic            reset,
    clk_period_meter_if.slave bus
);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_time_q;
    logic             valid_q;
    logic             timeout_q;

    // s1/s2 resolve metastability; s3 only delays s2 for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            hcnt        <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!bus.enable) begin
                state <= IDLE;
                cnt   <= '0;
                hcnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt   <= '0;
                        hcnt  <= '0;
                        state <= ARM;
                    end
                    ARM: begin
                        if (rise) begin
                            cnt   <= ONE;
                            hcnt  <= ONE;
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        // a rise closes the window even when cnt has just hit the limit
                        if (rise) begin
                            period_q    <= cnt;
                            high_time_q <= hcnt;
                            valid_q     <= 1'b1;
                            timeout_q   <= 1'b0;
                            cnt         <= ONE;
                            hcnt        <= ONE;
                        end else if (cnt == TIMEOUT_VAL) begin
                            timeout_q <= 1'b1;
                            cnt       <= '0;
                            hcnt      <= '0;
                            state     <= ARM;
                        end else begin
                            cnt  <= cnt + ONE;
                            hcnt <= hcnt + CNT_W'(s2);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        hcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.period    = period_q;
    assign bus.high_time = high_time_q;
    assign bus.valid     = valid_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - directed self-checking bench for clk_period_meter
module tb_clk_period_meter;
    localparam int CNT_W = 25;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int               vcyc[$];
    logic [CNT_W-1:0] vper[$];
    logic [CNT_W-1:0] vhi[$];
    int               last_valid_cyc = -1;
    int               to_rise_cyc = -1;
    logic             prev_to = 1'b0;
    logic             to_seen = 1'b0;

    clk_period_meter_if #(.CNT_W(CNT_W)) bus ();

    clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT_CYC(100)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            vcyc.push_back(cyc);
            vper.push_back(bus.period);
            vhi.push_back(bus.high_time);
            last_valid_cyc = cyc;
        end
        if (bus.timeout === 1'b1 && prev_to !== 1'b1) to_rise_cyc = cyc;
        if (bus.timeout === 1'b1) to_seen = 1'b1;
        prev_to = bus.timeout;
    end

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            bus.sig_in = v;
            @(negedge clk);
        end
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    task automatic clear_log();
        vcyc.delete();
        vper.delete();
        vhi.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.sig_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.period !== '0 || bus.high_time !== '0 || bus.valid !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got period=%0d high=%0d valid=%b timeout=%b, need all 0",
                     bus.period, bus.high_time, bus.valid, bus.timeout);
        end
        reset = 1'b0;
    endtask

    task automatic test_square_5_5();
        bus.enable = 1'b1;
        drive(1'b0, 5);
        clear_log();
        wave(5, 5, 4);
        checks++;
        if (vcyc.size() != 3) begin
            errors++;
            $display("FAIL sq55_count: got %0d valids, need 3", vcyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (vper[i] !== 25'd10 || vhi[i] !== 25'd5) begin
                    errors++;
                    $display("FAIL sq55_value[%0d]: got period=%0d high=%0d, need 10/5", i, vper[i], vhi[i]);
                end
            end
            checks++;
            if (vcyc[1] - vcyc[0] != 10 || vcyc[2] - vcyc[1] != 10) begin
                errors++;
                $display("FAIL sq55_spacing: got %0d,%0d cycles, need 10,10", vcyc[1] - vcyc[0], vcyc[2] - vcyc[1]);
            end
        end
        checks++;
        if (bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL sq55_timeout: got %b, need 0", bus.timeout);
        end
    endtask

    task automatic test_duty_3_9();
        clear_log();
        wave(3, 9, 3);
        checks++;
        if (vcyc.size() != 3) begin
            errors++;
            $display("FAIL duty_count: got %0d valids, need 3", vcyc.size());
        end else begin
            checks++;
            if (vper[0] !== 25'd10 || vhi[0] !== 25'd5) begin
                errors++;
                $display("FAIL duty_first: got period=%0d high=%0d, need 10/5", vper[0], vhi[0]);
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (vper[i] !== 25'd12 || vhi[i] !== 25'd3) begin
                    errors++;
                    $display("FAIL duty_value[%0d]: got period=%0d high=%0d, need 12/3", i, vper[i], vhi[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int ref_cyc;
        ref_cyc = last_valid_cyc;
        to_rise_cyc = -1;
        clear_log();
        drive(1'b0, 110);
        checks++;
        if (to_rise_cyc - ref_cyc != 100) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles after valid, need 100", to_rise_cyc - ref_cyc);
        end
        checks++;
        if (bus.timeout !== 1'b1 || bus.period !== 25'd12 || bus.high_time !== 25'd3 || vcyc.size() != 0) begin
            errors++;
            $display("FAIL timeout_hold: got timeout=%b period=%0d high=%0d valids=%0d, need 1/12/3/0",
                     bus.timeout, bus.period, bus.high_time, vcyc.size());
        end
        wave(5, 15, 1);
        checks++;
        if (vcyc.size() != 0 || bus.timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_arm: got valids=%0d timeout=%b, need 0/1", vcyc.size(), bus.timeout);
        end
        wave(5, 15, 1);
        checks++;
        if (vcyc.size() != 1 || bus.period !== 25'd20 || bus.high_time !== 25'd5 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_recover: got valids=%0d period=%0d high=%0d timeout=%b, need 1/20/5/0",
                     vcyc.size(), bus.period, bus.high_time, bus.timeout);
        end
    endtask

    task automatic test_timeout_boundary();
        bus.enable = 1'b0;
        drive(1'b0, 2);
        bus.enable = 1'b1;
        drive(1'b0, 3);
        clear_log();
        to_seen = 1'b0;
        wave(5, 95, 2);
        drive(1'b1, 5);
        drive(1'b0, 10);
        checks++;
        if (vcyc.size() != 2) begin
            errors++;
            $display("FAIL boundary_count: got %0d valids, need 2", vcyc.size());
        end else begin
            checks++;
            if (vper[0] !== 25'd100 || vper[1] !== 25'd100 || vhi[1] !== 25'd5) begin
                errors++;
                $display("FAIL boundary_value: got period=%0d,%0d high=%0d, need 100,100/5", vper[0], vper[1], vhi[1]);
            end
        end
        checks++;
        if (to_seen !== 1'b0) begin
            errors++;
            $display("FAIL boundary_timeout: got timeout seen=%b, need 0", to_seen);
        end
    endtask

    task automatic test_enable_gap();
        clear_log();
        bus.enable = 1'b0;
        wave(5, 5, 3);
        drive(1'b0, 5);
        checks++;
        if (vcyc.size() != 0 || bus.period !== 25'd100 || bus.high_time !== 25'd5 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL gap_hold: got valids=%0d period=%0d high=%0d timeout=%b, need 0/100/5/0",
                     vcyc.size(), bus.period, bus.high_time, bus.timeout);
        end
        bus.enable = 1'b1;
        drive(1'b0, 3);
        wave(5, 5, 3);
        checks++;
        if (vcyc.size() != 2 || bus.period !== 25'd10 || bus.high_time !== 25'd5) begin
            errors++;
            $display("FAIL gap_resume: got valids=%0d period=%0d high=%0d, need 2/10/5",
                     vcyc.size(), bus.period, bus.high_time);
        end
    endtask

    task automatic test_reset_mid_measure();
        drive(1'b1, 2);
        drive(1'b0, 3);
        clear_log();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.period !== '0 || bus.high_time !== '0 || bus.valid !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got period=%0d high=%0d valid=%b timeout=%b, need all 0",
                     bus.period, bus.high_time, bus.valid, bus.timeout);
        end
        drive(1'b0, 5);
        wave(5, 5, 1);
        checks++;
        if (vcyc.size() != 0) begin
            errors++;
            $display("FAIL midreset_arm: got %0d valids after one rise, need 0", vcyc.size());
        end
        wave(5, 5, 2);
        checks++;
        if (vcyc.size() != 2 || bus.period !== 25'd10 || bus.high_time !== 25'd5) begin
            errors++;
            $display("FAIL midreset_resume: got valids=%0d period=%0d high=%0d, need 2/10/5",
                     vcyc.size(), bus.period, bus.high_time);
        end
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.sig_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_square_5_5();
        test_duty_3_9();
        test_timeout();
        test_timeout_boundary();
        test_enable_gap();
        test_reset_mid_measure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period and high time of a slow, asynchronous square-wave input in system-clock cycles. It is the receive-side counterpart of the team's clock divider: it is used to check divided clocks and spike-driver outputs on the board, and to feed period values to display/debug logic. A 2-FF synchronizer and rising-edge detector feed an FSM-controlled pair of counters. Valid results are published with a one-cycle strobe, and a missing-edge condition raises a timeout flag.

## Interface
- CNT_W, 25, width of all counters and result outputs
- TIMEOUT_CYC, 20_000_000, max cycles allowed between rising edges before timeout; must be < 2^CNT_W

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  measurement enable; low forces IDLE
- sig_in  in  1  asynchronous signal to measure
- period  out  CNT_W  clk cycles between last two rising edges
- high_time  out  CNT_W  cycles sig was high within that period
- valid  out  1  one-cycle strobe when period/high_time update
- timeout  out  1  sticky flag: no edge within TIMEOUT_CYC

## Operation
- Synchronizer: s1 <= sig_in; s2 <= s1; s3 <= s2. rise = s2 & ~s3. All three flops are cleared by reset and run regardless of enable.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE: cnt=0, hcnt=0. Goes to ARM when enable=1.
  - ARM: waits for rise. On rise: cnt<=1, hcnt<=1, go to MEASURE.
  - MEASURE: on a non-rise cycle, cnt<=cnt+1 and hcnt<=hcnt+s2.
  - MEASURE, on rise: period<=cnt, high_time<=hcnt, valid<=1, timeout<=0. Then cnt<=1, hcnt<=1 and stay in MEASURE, so back-to-back periods are measured with no dead cycle.
  - MEASURE, on a non-rise cycle with cnt==TIMEOUT_CYC: timeout<=1, go to ARM, cnt/hcnt cleared. period and high_time hold their last values.
- Window definition: a measurement runs from one rise strobe (inclusive) to the next (exclusive). period = cycle count of the window; high_time = count of cycles in the window with s2=1.
- Simultaneous rise and cnt==TIMEOUT_CYC: rise wins. The measurement is valid with period=TIMEOUT_CYC, and no timeout is raised.
- enable low, in any state: next state is IDLE and counters clear. period, high_time and timeout hold. valid is 0.
- No counter can overflow because timeout caps cnt at TIMEOUT_CYC, and hcnt <= cnt always.
- timeout stays set until the next valid measurement or reset.

## Timing
- Reset (synchronous, sampled on posedge clk): state=IDLE; s1..s3, cnt, hcnt, period, high_time=0; valid=0; timeout=0.
- Input to rise latency: a sig_in transition that is stable before a clk edge produces rise 2 cycles later.
- valid is registered. It asserts on the cycle after the rise strobe is sampled, lasts exactly 1 cycle, and coincides with the new period/high_time values.
- First valid comes no earlier than the second rise after enable. The first edge only arms the meter.
- Minimum measurable period is 2 cycles. Pulses shorter than one clk may be missed; this is acceptable.
- Deasserting reset mid-measurement restarts from IDLE; no stale valid is produced.

## Test plan
- Square wave, 5 clk high / 5 clk low, enable=1 -> first valid after the second rise; period=10, high_time=5, a valid strobe every 10 cycles, timeout=0.
- Duty change to 3 high / 9 low -> next full window reports period=12, high_time=3.
- TIMEOUT_CYC=100 (override), one rise then sig_in held low -> timeout=1 exactly 100 cycles after the rise strobe, state ARM, period/high_time unchanged. Two later rises spaced 20 apart -> valid with period=20, timeout=0.
- TIMEOUT_CYC=100, rises exactly 100 cycles apart -> valid with period=100, timeout stays 0.
- enable dropped mid-window, then re-raised -> no valid until two new rises; outputs hold across the gap.
- reset asserted for 1 cycle mid-MEASURE -> all outputs 0 the following cycle; measurement resumes only after two fresh rises.
